// File: rtl/scoreboard.sv
// -----------------------------------------------------------------------------
// scoreboard
//
// Register-hazard scoreboard and issue controller between the IDU and the EXU.
// A small counter per architectural register tracks how many issued writes to
// that register have not yet been written back. The IDU->EXU valid/ready
// handshake is blocked while a source register still has a write in flight
// (RAW) or while the destination counter is saturated (FULL). Counters are
// released by WBU writebacks. A sticky error flag records a writeback to a
// register with no write in flight. A saturating counter records the cycles
// in which a valid instruction was held back by a hazard.
//
// Ports:
//   clk           clock, all state on the rising edge
//   rst           asynchronous active-low reset
//   valid_pre_i   IDU has a decoded instruction
//   ready_pre_o   ready back to the IDU (independent of valid_pre_i)
//   valid_post_o  valid to the EXU
//   ready_post_i  EXU ready
//   rena1_i       instruction reads rs1
//   raddr1_i      rs1 index
//   rena2_i       instruction reads rs2
//   raddr2_i      rs2 index
//   wena_i        instruction writes rd
//   waddr_i       rd index
//   wb_valid_i    WBU commits a register write this cycle
//   wb_waddr_i    committed rd index
//   busy_o        bit r set while register r has a write in flight; bit 0 = 0
//   err_o         sticky writeback-underflow flag, cleared only by reset
//   stall_cnt_o   saturating count of hazard-blocked valid cycles
// -----------------------------------------------------------------------------
module scoreboard #(
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int CW   = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_pre_i,
   output logic            ready_pre_o,
   output logic            valid_post_o,
   input  logic            ready_post_i,
   input  logic            rena1_i,
   input  logic [AW-1:0]   raddr1_i,
   input  logic            rena2_i,
   input  logic [AW-1:0]   raddr2_i,
   input  logic            wena_i,
   input  logic [AW-1:0]   waddr_i,
   input  logic            wb_valid_i,
   input  logic [AW-1:0]   wb_waddr_i,
   output logic [NREG-1:0] busy_o,
   output logic            err_o,
   output logic [31:0]     stall_cnt_o
);

   localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
   localparam logic [AW-1:0] REG_ZERO  = {AW{1'b0}};
   localparam logic [31:0]   STALL_MAX = 32'hFFFF_FFFF;

   // x0 has no counter; cnt_view_s gives it a constant zero entry so that
   // every register index can be looked up uniformly.
   logic [CW-1:0] cnt_r      [1:NREG-1];
   logic [CW-1:0] cnt_nxt_s  [1:NREG-1];
   logic [CW-1:0] cnt_view_s [0:NREG-1];

   logic          err_r;
   logic          err_nxt_s;
   logic [31:0]   stall_cnt_r;
   logic [31:0]   stall_cnt_nxt_s;

   logic          raw1_s;
   logic          raw2_s;
   logic          full_s;
   logic          hazard_s;
   logic          fire_s;
   logic          inc_en_s;
   logic          dec_en_s;
   logic          same_reg_s;

   // Uniform read view of the counters with a hard-wired zero for x0.
   always_comb begin
      cnt_view_s[0] = CNT_ZERO;
      for (int i = 1; i < NREG; i++) begin
         cnt_view_s[i] = cnt_r[i];
      end
   end

   // Hazard detection and handshake; only registered counters are consulted,
   // so ready_pre_o never depends on valid_pre_i.
   always_comb begin
      raw1_s       = rena1_i & (raddr1_i != REG_ZERO) & (cnt_view_s[raddr1_i] != CNT_ZERO);
      raw2_s       = rena2_i & (raddr2_i != REG_ZERO) & (cnt_view_s[raddr2_i] != CNT_ZERO);
      full_s       = wena_i & (waddr_i != REG_ZERO) & (cnt_view_s[waddr_i] == CNT_MAX);
      hazard_s     = raw1_s | raw2_s | full_s;
      valid_post_o = valid_pre_i & ~hazard_s;
      ready_pre_o  = ready_post_i & ~hazard_s;
      fire_s       = valid_pre_i & ready_post_i & ~hazard_s;
      inc_en_s     = fire_s & wena_i & (waddr_i != REG_ZERO);
      dec_en_s     = wb_valid_i & (wb_waddr_i != REG_ZERO);
      same_reg_s   = inc_en_s & dec_en_s & (waddr_i == wb_waddr_i);
   end

   // Per-register counter update; an issue and a writeback to the same
   // register in one cycle cancel out.
   always_comb begin
      for (int i = 1; i < NREG; i++) begin
         cnt_nxt_s[i] = cnt_r[i];
         if (same_reg_s) begin
            cnt_nxt_s[i] = cnt_r[i];
         end else if (inc_en_s && (waddr_i == AW'(i))) begin
            cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
         end else if (dec_en_s && (wb_waddr_i == AW'(i)) && (cnt_r[i] != CNT_ZERO)) begin
            cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
         end else begin
            cnt_nxt_s[i] = cnt_r[i];
         end
      end
   end

   // Sticky underflow flag and saturating stall counter next state.
   always_comb begin
      err_nxt_s = err_r;
      if (dec_en_s && (cnt_view_s[wb_waddr_i] == CNT_ZERO) && !same_reg_s) begin
         err_nxt_s = 1'b1;
      end else begin
         err_nxt_s = err_r;
      end

      stall_cnt_nxt_s = stall_cnt_r;
      if (valid_pre_i && hazard_s && (stall_cnt_r != STALL_MAX)) begin
         stall_cnt_nxt_s = stall_cnt_r + 32'd1;
      end else begin
         stall_cnt_nxt_s = stall_cnt_r;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 1; i < NREG; i++) begin
            cnt_r[i] <= CNT_ZERO;
         end
         err_r       <= 1'b0;
         stall_cnt_r <= 32'd0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            cnt_r[i] <= cnt_nxt_s[i];
         end
         err_r       <= err_nxt_s;
         stall_cnt_r <= stall_cnt_nxt_s;
      end
   end

   // Status outputs decoded straight from the state registers.
   always_comb begin
      busy_o[0] = 1'b0;
      for (int i = 1; i < NREG; i++) begin
         busy_o[i] = (cnt_r[i] != CNT_ZERO);
      end
      err_o       = err_r;
      stall_cnt_o = stall_cnt_r;
   end

endmodule

// File: tb/tb_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_scoreboard
//
// Directed bench for the register-hazard scoreboard. Each step drives inputs
// just after a rising edge, queues the values the step should produce, then
// pops and compares them against the DUT once they are due.
// -----------------------------------------------------------------------------
module tb_scoreboard;

   logic        clk;
   logic        rst;
   logic        valid_pre_i;
   logic        ready_pre_o;
   logic        valid_post_o;
   logic        ready_post_i;
   logic        rena1_i;
   logic [4:0]  raddr1_i;
   logic        rena2_i;
   logic [4:0]  raddr2_i;
   logic        wena_i;
   logic [4:0]  waddr_i;
   logic        wb_valid_i;
   logic [4:0]  wb_waddr_i;
   logic [31:0] busy_o;
   logic        err_o;
   logic [31:0] stall_cnt_o;

   int n_checks;
   int n_errors;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t exp_q[$];

   scoreboard #(.NREG(32), .AW(5), .CW(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_pre_i  (valid_pre_i),
      .ready_pre_o  (ready_pre_o),
      .valid_post_o (valid_post_o),
      .ready_post_i (ready_post_i),
      .rena1_i      (rena1_i),
      .raddr1_i     (raddr1_i),
      .rena2_i      (rena2_i),
      .raddr2_i     (raddr2_i),
      .wena_i       (wena_i),
      .waddr_i      (waddr_i),
      .wb_valid_i   (wb_valid_i),
      .wb_waddr_i   (wb_waddr_i),
      .busy_o       (busy_o),
      .err_o        (err_o),
      .stall_cnt_o  (stall_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push_exp(input string tag, input logic [31:0] e);
      exp_t item;
      item.tag = tag;
      item.exp = e;
      exp_q.push_back(item);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      exp_t item;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_errors++;
         $error("FAIL empty_queue observed=%h expected=<none>", obs);
      end else begin
         item = exp_q.pop_front();
         assert (obs === item.exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", item.tag, obs, item.exp);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      valid_pre_i  = 1'b0;
      ready_post_i = 1'b0;
      rena1_i      = 1'b0;
      raddr1_i     = 5'd0;
      rena2_i      = 1'b0;
      raddr2_i     = 5'd0;
      wena_i       = 1'b0;
      waddr_i      = 5'd0;
      wb_valid_i   = 1'b0;
      wb_waddr_i   = 5'd0;
   endtask

   task automatic issue(input logic [4:0] rd);
      idle();
      valid_pre_i  = 1'b1;
      ready_post_i = 1'b1;
      wena_i       = 1'b1;
      waddr_i      = rd;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b0;
      idle();
      repeat (2) tick();
      rst = 1'b1;

      // Reset then idle: a reader of x5 passes straight through.
      valid_pre_i = 1'b1;
      rena1_i     = 1'b1;
      raddr1_i    = 5'd5;
      push_exp("reset_valid_post", 32'd1);
      push_exp("reset_busy", 32'h0000_0000);
      push_exp("reset_err", 32'd0);
      push_exp("reset_stall", 32'd0);
      #1;
      pop_check(32'(valid_post_o));
      pop_check(busy_o);
      pop_check(32'(err_o));
      pop_check(stall_cnt_o);
      tick();

      // RAW stall on x5.
      issue(5'd5);
      push_exp("raw_issue_fire", 32'd1);
      #1;
      pop_check(32'(valid_post_o));
      tick();
      idle();
      valid_pre_i  = 1'b1;
      ready_post_i = 1'b1;
      rena2_i      = 1'b1;
      raddr2_i     = 5'd5;
      push_exp("raw_busy5", 32'h0000_0020);
      push_exp("raw_valid_post", 32'd0);
      push_exp("raw_ready_pre", 32'd0);
      #1;
      pop_check(busy_o);
      pop_check(32'(valid_post_o));
      pop_check(32'(ready_pre_o));
      tick();
      tick();
      push_exp("raw_stall2", 32'd2);
      pop_check(stall_cnt_o);
      wb_valid_i = 1'b1;
      wb_waddr_i = 5'd5;
      push_exp("raw_no_bypass", 32'd0);
      #1;
      pop_check(32'(valid_post_o));
      tick();
      wb_valid_i = 1'b0;
      push_exp("raw_busy_clear", 32'h0000_0000);
      push_exp("raw_release", 32'd1);
      push_exp("raw_stall3", 32'd3);
      #1;
      pop_check(busy_o);
      pop_check(32'(valid_post_o));
      pop_check(stall_cnt_o);
      tick();

      // Three writes in flight to x7, fourth blocked by FULL.
      issue(5'd7);
      repeat (3) tick();
      push_exp("full_valid_post", 32'd0);
      push_exp("full_ready_pre", 32'd0);
      push_exp("full_busy7", 32'h0000_0080);
      #1;
      pop_check(32'(valid_post_o));
      pop_check(32'(ready_pre_o));
      pop_check(busy_o);
      wb_valid_i = 1'b1;
      wb_waddr_i = 5'd7;
      tick();
      wb_valid_i = 1'b0;
      push_exp("full_unblocked", 32'd1);
      push_exp("full_stall4", 32'd4);
      #1;
      pop_check(32'(valid_post_o));
      pop_check(stall_cnt_o);
      tick();
      idle();
      wb_valid_i = 1'b1;
      wb_waddr_i = 5'd7;
      tick();
      tick();
      push_exp("drain_busy7_held", 32'h0000_0080);
      pop_check(busy_o);
      tick();
      wb_valid_i = 1'b0;
      push_exp("drain_busy7_clear", 32'h0000_0000);
      push_exp("drain_no_err", 32'd0);
      #1;
      pop_check(busy_o);
      pop_check(32'(err_o));

      // Same-cycle issue and writeback on x9 with one write in flight.
      issue(5'd9);
      tick();
      wb_valid_i = 1'b1;
      wb_waddr_i = 5'd9;
      tick();
      idle();
      push_exp("simul_busy9", 32'h0000_0200);
      push_exp("simul_err", 32'd0);
      #1;
      pop_check(busy_o);
      pop_check(32'(err_o));
      wb_valid_i = 1'b1;
      wb_waddr_i = 5'd9;
      tick();
      idle();
      push_exp("simul_drain9", 32'h0000_0000);
      pop_check(busy_o);

      // x0 never tracked; underflow on x3 is sticky.
      issue(5'd0);
      tick();
      idle();
      push_exp("x0_busy", 32'h0000_0000);
      pop_check(busy_o);
      wb_valid_i = 1'b1;
      wb_waddr_i = 5'd0;
      tick();
      push_exp("x0_wb_err", 32'd0);
      pop_check(32'(err_o));
      wb_waddr_i = 5'd3;
      tick();
      idle();
      push_exp("x3_underflow_err", 32'd1);
      pop_check(32'(err_o));
      repeat (2) tick();
      push_exp("err_sticky", 32'd1);
      pop_check(32'(err_o));

      // Stall counter saturation, then asynchronous reset mid-stall.
      issue(5'd11);
      tick();
      idle();
      valid_pre_i = 1'b1;
      rena1_i     = 1'b1;
      raddr1_i    = 5'd11;
      force dut.stall_cnt_r = 32'hFFFF_FFFD;
      #1;
      release dut.stall_cnt_r;
      repeat (4) tick();
      push_exp("stall_saturated", 32'hFFFF_FFFF);
      push_exp("stall_hazard_held", 32'd0);
      pop_check(stall_cnt_o);
      #1;
      pop_check(32'(valid_post_o));
      #2;
      rst = 1'b0;
      #1;
      push_exp("async_rst_stall", 32'd0);
      push_exp("async_rst_busy", 32'h0000_0000);
      push_exp("async_rst_err", 32'd0);
      push_exp("async_rst_passthru", 32'd1);
      pop_check(stall_cnt_o);
      pop_check(busy_o);
      pop_check(32'(err_o));
      pop_check(32'(valid_post_o));
      tick();
      rst = 1'b1;
      idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/scoreboard.md
# scoreboard

Register-hazard scoreboard and issue controller between the IDU and EXU of the multi-cycle core. Tracks in-flight writes per architectural register with small counters and blocks the IDU→EXU valid/ready handshake while a source or destination register is unsafe. Counters are released by WBU writeback. Also keeps a sticky underflow error flag and a stall-cycle performance counter.

## Interface
Parameters:
- NREG, 32, number of architectural registers (x0 hard-wired zero)
- AW, 5, register address width (log2 NREG)
- CW, 2, per-register in-flight counter width; max in-flight writes per register = 2^CW−1

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- valid_pre_i  in  1  IDU has a decoded instruction
- ready_pre_o  out  1  ready back to IDU
- valid_post_o  out  1  valid to EXU
- ready_post_i  in  1  EXU ready
- rena1_i  in  1  instruction reads rs1
- raddr1_i  in  AW  rs1 index
- rena2_i  in  1  instruction reads rs2
- raddr2_i  in  AW  rs2 index
- wena_i  in  1  instruction writes rd
- waddr_i  in  AW  rd index
- wb_valid_i  in  1  WBU commits a register write this cycle
- wb_waddr_i  in  AW  committed rd index
- busy_o  out  NREG  bit r = (cnt[r] != 0); bit 0 always 0
- err_o  out  1  sticky: writeback to a register whose counter is 0
- stall_cnt_o  out  32  cycles with valid_pre_i=1 blocked by hazard, saturating

## Operation
- State: cnt[1..NREG−1] (CW bits each), err, stall_cnt (32 bits). cnt[0] does not exist and reads as 0.
- Hazard (combinational, registered counters only):
  - RAW1 = rena1_i & raddr1_i!=0 & cnt[raddr1_i]!=0
  - RAW2 = same for rs2
  - FULL = wena_i & waddr_i!=0 & cnt[waddr_i]==2^CW−1
  - hazard = RAW1 | RAW2 | FULL. WAW alone does not stall.
- Handshake: valid_post_o = valid_pre_i & ~hazard; ready_pre_o = ready_post_i & ~hazard; fire = valid_pre_i & ready_post_i & ~hazard.
- Increment: fire & wena_i & waddr_i!=0 → cnt[waddr_i] +1.
- Decrement: wb_valid_i & wb_waddr_i!=0 & cnt[wb_waddr_i]!=0 → −1.
- Both events on the same register in one cycle: net unchanged.
- Writeback to a register with cnt==0 and no same-cycle increment: counter stays 0, err set; err clears only on reset.
- Writeback to x0, or issue with rd=x0: no counter effect, no error.
- stall_cnt +1 when valid_pre_i & hazard; holds at 0xFFFF_FFFF.

## Timing
- Reset (rst=0, asynchronous): all cnt=0, err_o=0, stall_cnt_o=0, busy_o=0. ready_pre_o/valid_post_o stay combinational and pass through, since no hazard exists with zero counters.
- Handshake path: zero latency, combinational from inputs and registered counters.
- Counters update on the clock edge after fire or writeback. busy_o reflects them the next cycle.
- No same-cycle bypass: a writeback that brings cnt[r] to 0 at edge t unblocks a dependent instruction at cycle t+1 at the earliest. The regfile write completes at the same edge, so the read in cycle t+1 is correct.
- Hazard never depends on valid_pre_i for ready_pre_o, so there is no combinational loop with the IDU FSM.
- Reset asserted mid-operation clears all tracking immediately. The surrounding pipeline is reset by the same rst, so no stale writebacks follow.

## Test plan
- Reset then idle: rst=0→1, valid_pre_i=1, rena1=1, raddr1=5 → valid_post_o=1, busy_o=0, err_o=0, stall_cnt_o=0.
- RAW stall: issue rd=5 (fire) → busy_o[5]=1 next cycle. Next instruction reads rs2=5 → valid_post_o=0, ready_pre_o=0, stall_cnt increments each cycle. wb_valid_i with wb_waddr=5 → busy_o[5]=0 after one edge, then the instruction issues.
- Multiple in-flight: issue rd=7 three times with no writeback → cnt[7]=3. Fourth issue to rd=7 is blocked by FULL. One writeback → fourth issue fires. Three more writebacks drop busy_o[7] only after the last one.
- Simultaneous issue and writeback to rd=9 with cnt=1 → cnt stays 1, busy_o[9]=1, err_o=0.
- x0 and error: issue rd=0 → busy_o=0. Writeback to x0 → err_o=0. Writeback to x3 with cnt=0 → err_o=1 and stays 1 until rst=0.
- Stall counter saturation: force stall_cnt near 0xFFFF_FFFE and hold a hazard for 4 cycles → stall_cnt_o=0xFFFF_FFFF. Assert rst mid-stall → all counters 0 asynchronously.
